// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for a 5-stage pipeline. It tracks the destination GPR of
// the instructions in E, M and W, and raises stallD on load-use hazards and on
// D-stage (branch/jr) hazards that forwarding cannot resolve.
// Optional feature: define HAZARD_MDU_EN to add a multiply/divide busy counter
// (ports md_start, md_use, md_busy) that contributes to stallD.
module hazard_scoreboard (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_v,
    input  logic       issue_wr,
    input  logic [4:0] issue_reg,
    input  logic       issue_ld,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic       use_rsE,
    input  logic       use_rtE,
    input  logic       use_rsD,
    input  logic       use_rtD,
    input  logic       flushE,
`ifdef HAZARD_MDU_EN
    input  logic       md_start,
    input  logic       md_use,
    output logic       md_busy,
`endif
    output logic       stallD,
    output logic       bubbleE,
    output logic [1:0] inflight
);

    typedef struct packed {
        logic       valid;
        logic [4:0] regNum;
        logic       ld;
    } trackSlotT;

    trackSlotT slotE, slotM, slotW;
    trackSlotT slotENext;

    logic loadUseHaz;
    logic dStageHaz;
    logic mduHaz;

`ifdef HAZARD_MDU_EN
    logic [2:0] mdCount;

    // Multiply/divide busy counter: a start is accepted only when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdCount <= '0;
        end else if (md_start && !md_busy) begin
            mdCount <= 3'd5;
        end else if (mdCount != 3'd0) begin
            mdCount <= mdCount - 3'd1;
        end
    end

    assign md_busy = (mdCount != 3'd0);
    assign mduHaz  = (md_use & md_busy) | (md_start & md_busy);
`else
    assign mduHaz = 1'b0;
`endif

    // Hazard detection from current slot state and D-stage sources.
    always_comb begin
        loadUseHaz = slotE.valid & slotE.ld &
                     ((use_rsE & (RsD == slotE.regNum)) |
                      (use_rtE & (RtD == slotE.regNum)));
        dStageHaz  = (slotE.valid &
                      ((use_rsD & (RsD == slotE.regNum)) |
                       (use_rtD & (RtD == slotE.regNum)))) |
                     (slotM.valid & slotM.ld &
                      ((use_rsD & (RsD == slotM.regNum)) |
                       (use_rtD & (RtD == slotM.regNum))));
        stallD     = loadUseHaz | dStageHaz | mduHaz;
        bubbleE    = stallD | flushE;
    end

    // Next E-slot contents: only real GPR writes that actually enter E.
    always_comb begin
        slotENext.valid  = issue_v & issue_wr & ~bubbleE & (issue_reg != 5'd0);
        slotENext.regNum = issue_reg;
        slotENext.ld     = issue_ld;
    end

    // Tracking pipeline: E->M->W->retire every cycle, never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotE <= '0;
            slotM <= '0;
            slotW <= '0;
        end else begin
            slotE <= slotENext;
            slotM <= slotE;
            slotW <= slotM;
        end
    end

    // Number of valid tracked entries, from registered state only.
    always_comb begin
        inflight = {1'b0, slotE.valid} + {1'b0, slotM.valid} + {1'b0, slotW.valid};
    end

endmodule
